// File: rtl/router_fsm_if.sv
// Interface for the router input-side control FSM.
// Groups the packet handshake, FIFO status and soft-reset inputs together with the
// FSM control outputs.
//   master : environment side (source, FIFOs, register stage) - drives FSM inputs
//   slave  : router_fsm side - drives the control/stall outputs
interface router_fsm_if;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_packet_valid;
   logic       write_enb_reg;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic       busy;

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_packet_valid,
      input  write_enb_reg, detect_add, lfd_state, ld_state,
      input  laf_state, full_state, rst_int_reg, busy
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_packet_valid,
      output write_enb_reg, detect_add, lfd_state, ld_state,
      output laf_state, full_state, rst_int_reg, busy
   );
endinterface

// File: rtl/router_fsm.sv
// Packet-level control FSM for the 1x3 router input side.
// Decodes the header address, sequences header/payload/parity loading, stalls the
// source while the destination FIFO is full or not yet drained, and abandons a packet
// when the destination port soft-resets.
// Ports:
//   clock  : system clock, rising edge
//   resetn : synchronous, active-low reset
//   bus    : router_fsm_if.slave - handshake, FIFO status inputs and control outputs
module router_fsm (
   input  logic          clock,
   input  logic          resetn,
   router_fsm_if.slave   bus
);

   typedef enum logic [2:0] {
      DecodeAddress,
      LoadFirstData,
      LoadData,
      LoadParity,
      FifoFullState,
      LoadAfterFull,
      WaitTillEmpty,
      CheckParityError
   } state_e;

   state_e     r_state;
   state_e     w_state_next;
   logic [1:0] r_addr;
   logic       w_sel_empty;
   logic       w_sel_sr;
   logic       w_hdr_empty;
   logic       w_hdr_ok;

   logic r_write_enb_reg, r_detect_add, r_lfd_state, r_ld_state;
   logic r_laf_state, r_full_state, r_rst_int_reg, r_busy;

   assign w_hdr_ok = bus.pkt_valid && (bus.data_in != 2'd3);

   // Status of the port latched at decode, and of the port named by the live header.
   always_comb begin
      w_sel_empty = 1'b0;
      w_sel_sr    = 1'b0;
      w_hdr_empty = 1'b0;
      unique case (r_addr)
         2'd0:    begin w_sel_empty = bus.fifo_empty_0; w_sel_sr = bus.soft_reset_0; end
         2'd1:    begin w_sel_empty = bus.fifo_empty_1; w_sel_sr = bus.soft_reset_1; end
         2'd2:    begin w_sel_empty = bus.fifo_empty_2; w_sel_sr = bus.soft_reset_2; end
         default: ;
      endcase
      unique case (bus.data_in)
         2'd0:    w_hdr_empty = bus.fifo_empty_0;
         2'd1:    w_hdr_empty = bus.fifo_empty_1;
         2'd2:    w_hdr_empty = bus.fifo_empty_2;
         default: ;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      // A soft reset of the selected port abandons the packet from any active state.
      if (w_sel_sr && (r_state != DecodeAddress)) begin
         w_state_next = DecodeAddress;
      end else begin
         unique case (r_state)
            DecodeAddress:
               if (w_hdr_ok) w_state_next = w_hdr_empty ? LoadFirstData : WaitTillEmpty;
            WaitTillEmpty:
               if (w_sel_empty) w_state_next = LoadFirstData;
            LoadFirstData:
               w_state_next = LoadData;
            LoadData:
               // Full has priority over end-of-packet so the parity byte is not lost.
               if (bus.fifo_full)       w_state_next = FifoFullState;
               else if (!bus.pkt_valid) w_state_next = LoadParity;
            FifoFullState:
               if (!bus.fifo_full) w_state_next = LoadAfterFull;
            LoadAfterFull:
               if (bus.parity_done)           w_state_next = DecodeAddress;
               else if (bus.low_packet_valid) w_state_next = LoadParity;
               else                           w_state_next = LoadData;
            LoadParity:
               w_state_next = CheckParityError;
            CheckParityError:
               w_state_next = bus.fifo_full ? FifoFullState : DecodeAddress;
            default:
               w_state_next = DecodeAddress;
         endcase
      end
   end

   // Outputs are registered from the next state so they change together with the state.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state         <= DecodeAddress;
         r_addr          <= 2'd0;
         r_write_enb_reg <= 1'b0;
         r_detect_add    <= 1'b1;
         r_lfd_state     <= 1'b0;
         r_ld_state      <= 1'b0;
         r_laf_state     <= 1'b0;
         r_full_state    <= 1'b0;
         r_rst_int_reg   <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == DecodeAddress) && w_hdr_ok) begin
            r_addr <= bus.data_in;
         end
         r_write_enb_reg <= (w_state_next == LoadData) || (w_state_next == LoadParity) ||
                            (w_state_next == LoadAfterFull);
         r_detect_add    <= (w_state_next == DecodeAddress);
         r_lfd_state     <= (w_state_next == LoadFirstData);
         r_ld_state      <= (w_state_next == LoadData);
         r_laf_state     <= (w_state_next == LoadAfterFull);
         r_full_state    <= (w_state_next == FifoFullState);
         r_rst_int_reg   <= (w_state_next == CheckParityError);
         r_busy          <= (w_state_next != DecodeAddress) && (w_state_next != LoadData);
      end
   end

   assign bus.write_enb_reg = r_write_enb_reg;
   assign bus.detect_add    = r_detect_add;
   assign bus.lfd_state     = r_lfd_state;
   assign bus.ld_state      = r_ld_state;
   assign bus.laf_state     = r_laf_state;
   assign bus.full_state    = r_full_state;
   assign bus.rst_int_reg   = r_rst_int_reg;
   assign bus.busy          = r_busy;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: table-driven vectors (one clock per record, outputs
// compared after the edge) followed by hand-written multi-cycle sequences.
module tb_router_fsm;

   typedef enum int {Da, Lfd, Ld, Lp, Ffs, Laf, Wte, Cpe} tstate_e;

   typedef struct {
      logic       resetn;
      logic       pv;
      logic [1:0] din;
      logic       full;
      logic [2:0] empty;  // {e2, e1, e0}
      logic [2:0] sr;     // {sr2, sr1, sr0}
      logic       pd;
      logic       lpv;
      tstate_e    exp;
   } vec_t;

   logic    clock;
   logic    resetn;
   vec_t    vecs[$];
   int      n_tests;
   int      n_fail;

   router_fsm_if bus ();

   router_fsm u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy}
   function automatic logic [7:0] exp_outs(tstate_e s);
      case (s)
         Da:      return 8'b0100_0000;
         Lfd:     return 8'b0010_0001;
         Ld:      return 8'b1001_0000;
         Lp:      return 8'b1000_0001;
         Ffs:     return 8'b0000_0101;
         Laf:     return 8'b1000_1001;
         Wte:     return 8'b0000_0001;
         default: return 8'b0000_0011;  // Cpe
      endcase
   endfunction

   function automatic logic [7:0] act_outs();
      return {bus.write_enb_reg, bus.detect_add, bus.lfd_state, bus.ld_state,
              bus.laf_state, bus.full_state, bus.rst_int_reg, bus.busy};
   endfunction

   task automatic add(input logic rn, input logic pv, input logic [1:0] din, input logic full,
                      input logic [2:0] empty, input logic [2:0] sr, input logic pd,
                      input logic lpv, input tstate_e exp);
      vec_t v;
      v.resetn = rn; v.pv = pv; v.din = din; v.full = full; v.empty = empty;
      v.sr = sr; v.pd = pd; v.lpv = lpv; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      resetn               = v.resetn;
      bus.pkt_valid        = v.pv;
      bus.data_in          = v.din;
      bus.fifo_full        = v.full;
      bus.fifo_empty_0     = v.empty[0];
      bus.fifo_empty_1     = v.empty[1];
      bus.fifo_empty_2     = v.empty[2];
      bus.soft_reset_0     = v.sr[0];
      bus.soft_reset_1     = v.sr[1];
      bus.soft_reset_2     = v.sr[2];
      bus.parity_done      = v.pd;
      bus.low_packet_valid = v.lpv;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: outputs actual=%b required=%b", name, act, req);
      end
   endtask

   initial begin
      vec_t dflt;
      int   cycles;
      bit   dropped;

      n_tests = 0;
      n_fail  = 0;
      dflt.resetn = 1'b1; dflt.pv = 1'b0; dflt.din = 2'd0; dflt.full = 1'b0;
      dflt.empty = 3'b111; dflt.sr = 3'b000; dflt.pd = 1'b0; dflt.lpv = 1'b0; dflt.exp = Da;
      drive(dflt);

      //  rn pv din full empty   sr     pd lpv exp
      // Reset, then a port-1 packet with two payload cycles.
      add(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, Da);
      add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, Lp);
      add(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, Cpe);
      add(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, Da);
      // Port 2 not empty for 4 cycles.
      add(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, Wte);
      add(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, Wte);
      add(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, Wte);
      add(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, Wte);
      add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Ld);
      // Full for 3 cycles in LOAD_DATA.
      add(1, 1, 2'd2, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 1, 2'd2, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 1, 2'd2, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Laf);
      add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Ld);
      // LAF with low_packet_valid -> LP -> CPE -> DECODE.
      add(1, 1, 2'd2, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 0, 2'd2, 0, 3'b111, 3'b000, 0, 0, Laf);
      add(1, 0, 2'd2, 0, 3'b111, 3'b000, 0, 1, Lp);
      add(1, 0, 2'd2, 0, 3'b111, 3'b000, 0, 0, Cpe);
      add(1, 0, 2'd2, 0, 3'b111, 3'b000, 0, 0, Da);
      // LAF with parity_done (beats low_packet_valid) -> DECODE.
      add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, Laf);
      add(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 1, Da);
      // CHECK_PARITY_ERROR with full -> FFS.
      add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, Lp);
      add(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, Cpe);
      add(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, Laf);
      add(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 0, Da);
      // Full and pkt_valid low together in LOAD_DATA: full wins.
      add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(1, 0, 2'd1, 1, 3'b111, 3'b000, 0, 0, Ffs);
      add(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, Laf);
      add(1, 0, 2'd1, 0, 3'b111, 3'b000, 1, 0, Da);
      // Invalid address and idle source stay in DECODE.
      add(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, Da);
      add(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, Da);
      // Soft resets while waiting on port 0.
      add(1, 1, 2'd0, 0, 3'b110, 3'b000, 0, 0, Wte);
      add(1, 1, 2'd0, 0, 3'b110, 3'b010, 0, 0, Wte);
      add(1, 1, 2'd0, 0, 3'b110, 3'b001, 0, 0, Da);
      // Selected soft reset overrides the unconditional LFD -> LD step.
      add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd0, 0, 3'b111, 3'b001, 0, 0, Da);
      // Soft reset ignored in DECODE, then taken in LOAD_DATA over end-of-packet.
      add(1, 1, 2'd1, 0, 3'b111, 3'b010, 0, 0, Lfd);
      add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(1, 0, 2'd1, 0, 3'b111, 3'b010, 0, 0, Da);
      // Reset mid-packet aborts with no write enable.
      add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Lfd);
      add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Ld);
      add(0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, Da);
      add(1, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0, Wte);
      add(1, 0, 2'd1, 0, 3'b101, 3'b010, 0, 0, Da);

      foreach (vecs[i]) begin
         @(negedge clock);
         drive(vecs[i]);
         @(posedge clock);
         #1;
         check($sformatf("vec%0d", i), act_outs(), exp_outs(vecs[i].exp));
      end

      // Minimum packet: header edge to DECODE takes 5 clocks.
      @(negedge clock);
      drive(dflt);
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd2;
      cycles  = 0;
      dropped = 1'b0;
      do begin
         @(posedge clock);
         #1;
         cycles++;
         if (bus.ld_state && !dropped) begin
            @(negedge clock);
            bus.pkt_valid = 1'b0;
            dropped       = 1'b1;
         end
      end while (!bus.detect_add && cycles < 20);
      check("min_packet_cycles", 8'(cycles), 8'd5);

      // Busy must stall the source through LOAD_FIRST_DATA and drop in LOAD_DATA.
      @(negedge clock);
      drive(dflt);
      bus.pkt_valid = 1'b1;
      @(posedge clock);
      #1;
      check("lfd_busy", {7'd0, bus.busy}, 8'd1);
      @(posedge clock);
      #1;
      check("ld_not_busy", {7'd0, bus.busy}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-level control FSM for the 1x3 router input side. It sits directly upstream of the three per-port output FIFOs and the input register/parity stage. It decodes the header address and sequences header, payload and parity loading. It drives the FIFO write-enable qualifier and the `lfd_state` header tag, stalls the source via `busy` while a destination FIFO is full or not yet drained, and abandons a packet when its destination port soft-resets.

## Interface
Parameters:
- none (3 destination ports and a 2-bit address are fixed)

Ports:
- `clock` in 1: system clock, all state changes on rising edge
- `resetn` in 1: synchronous, active-low reset
- `pkt_valid` in 1: source asserts for header and payload bytes; deasserts on the parity byte
- `data_in` in 2: header address bits `[1:0]`, sampled in DECODE_ADDRESS; value 3 is invalid
- `fifo_full` in 1: full flag of the currently selected destination FIFO
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-port FIFO empty flags
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-port read-timeout soft resets
- `parity_done` in 1: register stage has captured the parity byte
- `low_packet_valid` in 1: `pkt_valid` fell while the FSM was stalled in FIFO_FULL_STATE
- `write_enb_reg` out 1: qualifies the FIFO write of the byte held in the register stage
- `detect_add` out 1: FSM is in DECODE_ADDRESS
- `lfd_state` out 1: load first data; tags the header byte in the FIFO
- `ld_state` out 1: load payload data
- `laf_state` out 1: load after full
- `full_state` out 1: stalled on a full FIFO
- `rst_int_reg` out 1: clears the internal parity-check registers
- `busy` out 1: stall to the source; the source must hold its data while this is 1

## Operation
- 3-bit state register with 8 states: DECODE_ADDRESS (reset state), LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- `addr_q[1:0]` latches `data_in` on any cycle in DECODE_ADDRESS with `pkt_valid`=1 and `data_in`≠3. It is held until the next decode.
- `sel_empty` = `fifo_empty_<addr_q>`. `sel_sr` = `soft_reset_<addr_q>`.
- Transitions, evaluated in priority order:
  - `sel_sr`=1 in any state other than DECODE_ADDRESS → DECODE_ADDRESS.
  - DECODE_ADDRESS:
    - `pkt_valid`, `data_in`=k (k≤2), `fifo_empty_k`=1 → LOAD_FIRST_DATA.
    - `pkt_valid`, `data_in`=k (k≤2), `fifo_empty_k`=0 → WAIT_TILL_EMPTY.
    - `data_in`=3 or `pkt_valid`=0 → stay.
  - WAIT_TILL_EMPTY: `sel_empty` → LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
  - LOAD_DATA: `fifo_full` → FIFO_FULL_STATE; else if !`pkt_valid` → LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: !`fifo_full` → LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: `parity_done` → DECODE_ADDRESS; else if `low_packet_valid` → LOAD_PARITY; else → LOAD_DATA.
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- Outputs are Moore, decoded from the state register only:
  - `detect_add` = DECODE_ADDRESS.
  - `lfd_state` = LOAD_FIRST_DATA.
  - `ld_state` = LOAD_DATA.
  - `laf_state` = LOAD_AFTER_FULL.
  - `full_state` = FIFO_FULL_STATE.
  - `rst_int_reg` = CHECK_PARITY_ERROR.
  - `write_enb_reg` = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - `busy` = 1 in every state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Reset: `resetn`=0 at a clock edge → state=DECODE_ADDRESS, `addr_q`=0. Outputs then read `detect_add`=1 and every other output 0.
- Reset during a packet aborts it immediately on that edge. No further write enable is issued.
- Transitions take effect one clock after the inputs are sampled. Outputs change in the same cycle as the state.
- Header-to-first-payload latency with the destination empty:
  - cycle 0: DECODE_ADDRESS
  - cycle 1: LOAD_FIRST_DATA
  - cycle 2: LOAD_DATA
- Source handshake: when `busy`=1 at an edge, the source holds `data_in` and `pkt_valid`.
- `fifo_full` and `pkt_valid`=0 in the same LOAD_DATA cycle: full wins, go to FIFO_FULL_STATE.
- `soft_reset` of a non-selected port is ignored. `soft_reset` of the selected port overrides every other condition in the same cycle.
- A minimum packet (header, 1 payload, parity) with no stalls takes 5 cycles from the DECODE_ADDRESS header cycle back to DECODE_ADDRESS.

## Test plan
- Reset, then `pkt_valid`=1, `data_in`=1, `fifo_empty_1`=1. Then 2 payload cycles, then `pkt_valid`=0. Required state sequence: DECODE → LFD → LD → LD → LP → CPE → DECODE. `lfd_state` is high for exactly 1 cycle, `rst_int_reg` for 1 cycle.
- `data_in`=2 with `fifo_empty_2`=0 for 4 cycles, then 1. Required: WAIT_TILL_EMPTY for 4 cycles with `busy`=1, then LFD.
- In LOAD_DATA, raise `fifo_full` for 3 cycles with `pkt_valid`=1, then drop it. Required: FFS for 3 cycles (`full_state`=1, `write_enb_reg`=0), then LAF, then LD.
- FFS, then LAF with `low_packet_valid`=1 and `parity_done`=0. Required: LP, then CPE. Repeat with `parity_done`=1: LAF → DECODE.
- `data_in`=3 with `pkt_valid`=1. Required: stays in DECODE, `addr_q` unchanged.
- `soft_reset_0` pulse while in WAIT_TILL_EMPTY for port 0. Required: DECODE on the next cycle. A `soft_reset_1` pulse in the same situation has no effect.
